// File: rtl/mem_sram_ctrl.sv
// ============================================================================
// Module   : mem_sram_ctrl
// Brief    : Single-port SRAM initiator with zero-fill after reset, a request
//            channel and a single-outstanding read-response channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_sram_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int ADDR  = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             init_done,
    output logic             Mem_WE,
    output logic [ADDR-1:0]  Mem_Address,
    output logic [WIDTH-1:0] Mem_Data,
    input  logic [WIDTH-1:0] Mem_Q
);

    localparam int              CNT_W   = ADDR + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_RSP   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_init_done;
    logic             w_init_nxt;
    logic             r_we;
    logic             w_we_nxt;
    logic [ADDR-1:0]  r_addr;
    logic [ADDR-1:0]  w_addr_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_rsp_valid;
    logic             w_rsp_valid_nxt;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic [WIDTH-1:0] w_rsp_rdata_nxt;
    logic             r_oor;
    logic             w_oor_nxt;

    logic w_acc;
    logic w_in_range;
    logic w_clear_done;

    assign req_ready    = (r_state == S_IDLE);
    assign w_acc        = req_valid & req_ready;
    assign w_in_range   = ({1'b0, req_addr} < c_DEPTH);
    assign w_clear_done = (r_cnt == c_DEPTH);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (w_clear_done)          w_state_nxt = S_IDLE;
            S_IDLE:  if (w_acc && !req_write)   w_state_nxt = S_RD;
            S_RD:                               w_state_nxt = S_RSP;
            S_RSP:   if (rsp_ready)             w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_cnt_nxt       = r_cnt;
        w_init_nxt      = r_init_done;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_oor_nxt       = r_oor;
        case (r_state)
            S_CLEAR: begin
                if (w_clear_done) begin
                    w_init_nxt = 1'b1;
                end else begin
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_cnt[ADDR-1:0];
                    w_data_nxt = '0;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (w_acc) begin
                    w_addr_nxt = req_addr;
                    if (req_write) begin
                        // Out-of-range writes are consumed but never reach the array.
                        w_we_nxt   = w_in_range;
                        w_data_nxt = req_wdata;
                    end else begin
                        w_oor_nxt = !w_in_range;
                    end
                end
            end
            S_RD: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = r_oor ? '0 : Mem_Q;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_we_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_oor       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_oor       <= w_oor_nxt;
        end
    end

    assign init_done   = r_init_done;
    assign Mem_WE      = r_we;
    assign Mem_Address = r_addr;
    assign Mem_Data    = r_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;

    a_we_source: assert property (@(posedge Clock) disable iff (!Reset_n)
        Mem_WE |-> ((r_state == S_CLEAR) || $past(w_acc && req_write)));

    a_rsp_hold: assert property (@(posedge Clock) disable iff (!Reset_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_ctrl.sv
// ============================================================================
// Module   : tb_mem_sram_ctrl
// Brief    : Drives a depth-8 and a depth-6 controller in lockstep, each with a
//            behavioural SRAM, and checks them against array reference models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_sram_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;

    logic       a_req_ready, a_rsp_valid, a_init_done, a_we;
    logic [7:0] a_rsp_rdata, a_data, a_q;
    logic [2:0] a_addr;
    logic       b_req_ready, b_rsp_valid, b_init_done, b_we;
    logic [7:0] b_rsp_rdata, b_data, b_q;
    logic [2:0] b_addr;

    int checks = 0;
    int errors = 0;
    int we_cnt_a = 0;
    int oor_we_b = 0;

    logic [7:0] sram_a [0:7];
    logic [7:0] sram_b [0:5];
    logic [7:0] ref_a  [0:7];
    logic [7:0] ref_b  [0:5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_sram_ctrl #(.WIDTH(8), .DEPTH(8), .ADDR(3)) u_dut_a (
        .Clock(clk), .Reset_n(rst_n),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .init_done(a_init_done),
        .Mem_WE(a_we), .Mem_Address(a_addr), .Mem_Data(a_data), .Mem_Q(a_q)
    );

    mem_sram_ctrl #(.WIDTH(8), .DEPTH(6), .ADDR(3)) u_dut_b (
        .Clock(clk), .Reset_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .init_done(b_init_done),
        .Mem_WE(b_we), .Mem_Address(b_addr), .Mem_Data(b_data), .Mem_Q(b_q)
    );

    // Behavioural SRAMs: synchronous write, combinational read.
    always @(posedge clk) begin
        if (a_we) sram_a[a_addr] <= a_data;
        if (b_we && b_addr < 3'd6) sram_b[b_addr] <= b_data;
        if (a_we) we_cnt_a <= we_cnt_a + 1;
        if (b_we && b_addr >= 3'd6) oor_we_b <= oor_we_b + 1;
    end
    assign a_q = sram_a[a_addr];
    assign b_q = (b_addr < 3'd6) ? sram_b[b_addr] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(a_req_ready && b_req_ready) && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 32'(a_req_ready && b_req_ready), 1);
    endtask

    task automatic reset_vals();
        chk("rst_we_a",    a_we, 0);
        chk("rst_addr_a",  a_addr, 0);
        chk("rst_data_a",  a_data, 0);
        chk("rst_valid_a", a_rsp_valid, 0);
        chk("rst_rdata_a", a_rsp_rdata, 0);
        chk("rst_init_a",  a_init_done, 0);
        chk("rst_ready_a", a_req_ready, 0);
        chk("rst_init_b",  b_init_done, 0);
        chk("rst_ready_b", b_req_ready, 0);
    endtask

    // Entered just after reset release; follows the zero-fill edge by edge.
    task automatic init_check();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("clr_we_a", a_we, 32'(i < 8));
            if (i < 8) chk("clr_addr_a", a_addr, i);
            chk("clr_data_a", a_data, 0);
            chk("init_a", a_init_done, 32'(i >= 8));
            chk("rdy_a", a_req_ready, 32'(i >= 8));
            chk("clr_we_b", b_we, 32'(i < 6));
            if (i < 6) chk("clr_addr_b", b_addr, i);
            chk("init_b", b_init_done, 32'(i >= 6));
        end
        for (int k = 0; k < 8; k++) ref_a[k] = 8'h00;
        for (int k = 0; k < 6; k++) ref_b[k] = 8'h00;
    endtask

    task automatic do_write(input logic [2:0] ad, input logic [7:0] d);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = ad; req_wdata = d;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        chk("wr_we_a",   a_we, 1);
        chk("wr_addr_a", a_addr, ad);
        chk("wr_data_a", a_data, d);
        chk("wr_we_b",   b_we, 32'(ad < 3'd6));
        ref_a[ad] = d;
        if (ad < 3'd6) ref_b[ad] = d;
    endtask

    task automatic do_read(input logic [2:0] ad, input int stall);
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        exp_a = ref_a[ad];
        exp_b = (ad < 3'd6) ? ref_b[ad] : 8'h00;
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = ad;
        tick();
        req_valid = 1'b0;
        chk("rd_e0_valid_a", a_rsp_valid, 0);
        chk("rd_e0_ready_a", a_req_ready, 0);
        chk("rd_e0_we_a",    a_we, 0);
        tick();
        chk("rd_valid_a", a_rsp_valid, 1);
        chk("rd_data_a",  a_rsp_rdata, exp_a);
        chk("rd_valid_b", b_rsp_valid, 1);
        chk("rd_data_b",  b_rsp_rdata, exp_b);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid_a", a_rsp_valid, 1);
            chk("stall_data_a",  a_rsp_rdata, exp_a);
            chk("stall_ready_a", a_req_ready, 0);
            chk("stall_we_a",    a_we, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_clear_a", a_rsp_valid, 0);
        chk("rsp_clear_b", b_rsp_valid, 0);
        chk("rsp_ready_a", a_req_ready, 1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals();
        rst_n = 1'b1;
        init_check();

        do_read(3'd5, 0);
        do_write(3'd3, 8'hA5);
        do_read(3'd3, 0);

        base = we_cnt_a;
        do_write(3'd0, 8'h11);
        do_write(3'd1, 8'h22);
        do_write(3'd7, 8'h33);
        tick();
        tick();
        chk("we_burst_len", we_cnt_a - base, 3);
        do_read(3'd0, 0);
        do_read(3'd1, 0);
        do_read(3'd7, 0);

        do_read(3'd2, 5);

        do_write(3'd6, 8'hFF);
        do_read(3'd6, 0);
        chk("oor_we_b", oor_we_b, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(3'($urandom_range(0, 7)), 8'($urandom));
            else
                do_read(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_valid_a", a_rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_a", a_rsp_valid, 0);
        chk("mid_rst_init_a",  a_init_done, 0);
        chk("mid_rst_ready_a", a_req_ready, 0);
        chk("mid_rst_valid_b", b_rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_check();
        for (int k = 0; k < 8; k++) do_read(3'(k), 0);
        chk("oor_we_b_end", oor_we_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
